// File: rtl/dmc_pkg.sv
// Shared types and widths for the DMC request path, controller and cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmc_pkg;

    localparam int DMC_BLOCK_SIZE      = 4;
    localparam int DMC_ADDRESS_SIZE    = 16;
    localparam int BLOCK_OFFSET_LENGTH = 2;
    localparam int INDEX_LENGTH        = 4;
    localparam int TAG_LENGTH          = DMC_ADDRESS_SIZE - INDEX_LENGTH - BLOCK_OFFSET_LENGTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_WAIT  = 2'd3
    } dmc_state_e;

    typedef struct packed {
        logic                        write;
        logic [DMC_ADDRESS_SIZE-1:0] address;
        logic [DMC_BLOCK_SIZE-1:0]   data;
    } dmc_req_t;

endpackage

// File: rtl/dmc_req_fifo.sv
// Request FIFO: storage array, wrapping pointers and an occupancy count.
// Latency: push visible in count/head after 1 edge; head is combinational from storage.
// Backpressure: push_rdy = count < DEPTH from the registered count only.
module dmc_req_fifo
    import dmc_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = dmc_req_t,
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          push_vld,
    output logic          push_rdy,
    input  entry_t        push_dat,
    input  logic          pop_vld,
    output entry_t        head_dat,
    output logic [CW-1:0] count
);

    localparam int            AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            push_fire;
    logic            pop_fire;

    assign push_rdy  = (count_q < DEPTH_C);
    assign push_fire = push_vld && push_rdy;
    assign pop_fire  = pop_vld && (count_q != '0);
    assign head_dat  = mem_q[rd_ptr_q];
    assign count     = count_q;

    always_ff @(posedge clk_i) begin
        if (push_fire) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally; count alone decides full/empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_fire) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_fire, pop_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/dmc_request_queue.sv
// CPU request queue feeding DMC_Controller one transaction at a time.
// Latency: push->start 2 edges from idle; start->rsp_valid >= 3 edges.
// Backpressure: req_ready_o drops when queue holds QUEUE_DEPTH entries; responses are never stalled.
module dmc_request_queue
    import dmc_pkg::*;
#(
    parameter int  BLOCK_SIZE   = 4,
    parameter int  ADDRESS_SIZE = 16,
    parameter int  QUEUE_DEPTH  = 4,
    localparam int CW           = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_write_i,
    input  logic [ADDRESS_SIZE-1:0] req_address_i,
    input  logic [BLOCK_SIZE-1:0]   req_data_i,
    output logic                    start_o,
    output logic                    read_o,
    output logic                    write_o,
    output logic [ADDRESS_SIZE-1:0] address_o,
    output logic [BLOCK_SIZE-1:0]   data_o,
    input  logic                    ready_i,
    input  logic [BLOCK_SIZE-1:0]   data_i,
    output logic                    rsp_valid_o,
    output logic                    rsp_write_o,
    output logic [BLOCK_SIZE-1:0]   rsp_data_o,
    output logic [CW-1:0]           count_o,
    output logic                    idle_o
);

    typedef struct packed {
        logic                    write;
        logic [ADDRESS_SIZE-1:0] address;
        logic [BLOCK_SIZE-1:0]   data;
    } req_t;

    dmc_state_e             state_q;
    dmc_state_e             state_d;
    req_t                   push_dat;
    req_t                   head_dat;
    req_t                   cmd_q;
    logic                   pop;
    logic                   start;
    logic                   rsp_fire;
    logic                   rsp_valid_q;
    logic                   rsp_write_q;
    logic [BLOCK_SIZE-1:0]  rsp_data_q;
    logic [CW-1:0]          count;

    assign push_dat = '{write: req_write_i, address: req_address_i, data: req_data_i};

    dmc_req_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .push_vld (req_valid_i),
        .push_rdy (req_ready_o),
        .push_dat (push_dat),
        .pop_vld  (pop),
        .head_dat (head_dat),
        .count    (count)
    );

    // HOLD exists so a ready_i left high by the previous transaction cannot complete this one.
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        start    = 1'b0;
        rsp_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                start   = 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ready_i) begin
                    rsp_fire = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The command register keeps address/data stable until the next pop.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cmd_q <= '0;
        end else if (pop) begin
            cmd_q <= head_dat;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_fire;
            if (rsp_fire) begin
                rsp_write_q <= cmd_q.write;
                rsp_data_q  <= cmd_q.write ? '0 : data_i;
            end
        end
    end

    assign start_o     = start;
    assign read_o      = start && !cmd_q.write;
    assign write_o     = start && cmd_q.write;
    assign address_o   = cmd_q.address;
    assign data_o      = cmd_q.data;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_write_o = rsp_write_q;
    assign rsp_data_o  = rsp_data_q;
    assign count_o     = count;
    assign idle_o      = (state_q == ST_IDLE) && (count == '0);

endmodule

// File: tb/tb_dmc_request_queue.sv
// Bench for dmc_request_queue: transaction-level model, behavioural controller, directed scenarios.
module tb_dmc_request_queue;

    localparam int BS = 4;
    localparam int AS = 16;
    localparam int QD = 4;
    localparam int CW = $clog2(QD + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid_i, req_ready_o, req_write_i;
    logic [AS-1:0] req_address_i;
    logic [BS-1:0] req_data_i;
    logic          start_o, read_o, write_o;
    logic [AS-1:0] address_o;
    logic [BS-1:0] data_o;
    logic          ready_i;
    logic [BS-1:0] data_i;
    logic          rsp_valid_o, rsp_write_o;
    logic [BS-1:0] rsp_data_o;
    logic [CW-1:0] count_o;
    logic          idle_o;

    always #5 clk = ~clk;

    dmc_request_queue #(.BLOCK_SIZE(BS), .ADDRESS_SIZE(AS), .QUEUE_DEPTH(QD)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_address_i(req_address_i), .req_data_i(req_data_i),
        .start_o(start_o), .read_o(read_o), .write_o(write_o),
        .address_o(address_o), .data_o(data_o),
        .ready_i(ready_i), .data_i(data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_write_o(rsp_write_o), .rsp_data_o(rsp_data_o),
        .count_o(count_o), .idle_o(idle_o)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Behavioural controller: drops ready on start, raises it again lat cycles later.
    logic [BS-1:0] mem [256];
    int            lat  = 2;
    bit            hold = 1'b0;
    bit            tie  = 1'b0;
    bit            c_busy, c_w;
    int            c_cnt;
    logic [AS-1:0] c_a;
    logic [BS-1:0] c_d;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = BS'(i);
        ready_i = 1'b1;
        data_i  = '0;
        c_busy  = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                c_busy = 1'b0;
            end else if (start_o) begin
                c_busy = 1'b1;
                c_w    = write_o;
                c_a    = address_o;
                c_d    = data_o;
                c_cnt  = lat;
            end else if (c_busy) begin
                if (c_cnt > 0) c_cnt--;
                if (c_cnt == 0) begin
                    c_busy = 1'b0;
                    if (c_w) begin
                        mem[c_a[7:0]] = c_d;
                        data_i = '0;
                    end else begin
                        data_i = mem[c_a[7:0]];
                    end
                end
            end
            ready_i = tie | (!c_busy && !hold);
        end
    end

    // Transaction-level model: a queue of pending requests plus the age of the one in flight.
    typedef struct {
        bit            w;
        logic [AS-1:0] a;
        logic [BS-1:0] d;
    } mreq_t;

    mreq_t         mq[$];
    mreq_t         m_cur;
    bit            m_busy = 1'b0, m_rsp = 1'b0, m_has = 1'b0, m_rw = 1'b0;
    int            m_age = 0;
    logic [BS-1:0] m_rd;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_busy = 1'b0;
            m_rsp  = 1'b0;
            m_has  = 1'b0;
            m_age  = 0;
        end else begin
            int sz0;
            sz0   = mq.size();
            m_rsp = 1'b0;
            if (m_busy) begin
                if (m_age >= 2 && ready_i) begin
                    m_rsp  = 1'b1;
                    m_rw   = m_cur.w;
                    m_rd   = m_cur.w ? '0 : data_i;
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end else if (sz0 > 0) begin
                m_cur  = mq.pop_front();
                m_busy = 1'b1;
                m_has  = 1'b1;
                m_age  = 0;
            end
            if (req_valid_i && sz0 < QD) begin
                mreq_t r;
                r.w = req_write_i;
                r.a = req_address_i;
                r.d = req_data_i;
                mq.push_back(r);
            end
        end
    end

    // Per-cycle compare plus logs used by the directed checks.
    logic [AS-1:0] issued_q[$];
    int            rsp_cnt = 0;
    int            last_rsp_cyc = 0, last_start_cyc = 0;
    logic          last_rsp_write = 1'b0, last_start_read = 1'b0;
    logic [BS-1:0] last_rsp_data = '0;

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            bit st;
            st = m_busy && (m_age == 0);
            chk("count_o", 32'(count_o), mq.size());
            chk("req_ready_o", 32'(req_ready_o), 32'(mq.size() < QD));
            chk("idle_o", 32'(idle_o), 32'(!m_busy && mq.size() == 0));
            chk("start_o", 32'(start_o), 32'(st));
            chk("read_o", 32'(read_o), 32'(st && !m_cur.w));
            chk("write_o", 32'(write_o), 32'(st && m_cur.w));
            chk("address_o", 32'(address_o), m_has ? 32'(m_cur.a) : 32'd0);
            chk("data_o", 32'(data_o), m_has ? 32'(m_cur.d) : 32'd0);
            chk("rsp_valid_o", 32'(rsp_valid_o), 32'(m_rsp));
            if (m_rsp) begin
                chk("rsp_write_o", 32'(rsp_write_o), 32'(m_rw));
                chk("rsp_data_o", 32'(rsp_data_o), 32'(m_rd));
            end
        end
        if (rst_n && start_o) begin
            issued_q.push_back(address_o);
            last_start_cyc  = cyc;
            last_start_read = read_o;
        end
        if (rst_n && rsp_valid_o) begin
            rsp_cnt++;
            last_rsp_cyc   = cyc;
            last_rsp_write = rsp_write_o;
            last_rsp_data  = rsp_data_o;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input bit w, input logic [AS-1:0] a, input logic [BS-1:0] d);
        int n = 0;
        req_valid_i   = 1'b1;
        req_write_i   = w;
        req_address_i = a;
        req_data_i    = d;
        while (!req_ready_o && n < 200) begin
            step();
            n++;
        end
        if (!req_ready_o) fail_now("push_wait");
        step();
        req_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!idle_o && n < 400);
        if (!idle_o) fail_now(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int base;
    int n0;

    initial begin
        rst_n         = 1'b0;
        req_valid_i   = 1'b0;
        req_write_i   = 1'b0;
        req_address_i = '0;
        req_data_i    = '0;

        // Reset for one cycle, then check every output against its reset value.
        step();
        rst_n = 1'b1;
        chk("rst_req_ready", 32'(req_ready_o), 1);
        chk("rst_idle", 32'(idle_o), 1);
        chk("rst_count", 32'(count_o), 0);
        chk("rst_start", 32'(start_o), 0);
        chk("rst_read", 32'(read_o), 0);
        chk("rst_write", 32'(write_o), 0);
        chk("rst_address", 32'(address_o), 0);
        chk("rst_data", 32'(data_o), 0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("rst_rsp_write", 32'(rsp_write_o), 0);
        chk("rst_rsp_data", 32'(rsp_data_o), 0);
        chk_en = 1'b1;

        // Single read of 0x0000, then a read of 0x0003 (memory holds each address's low bits).
        push(1'b0, 16'h0000, 4'h0);
        chk("read0_count_after_push", 32'(count_o), 1);
        step();
        chk("read0_start", 32'(start_o), 1);
        chk("read0_read", 32'(read_o), 1);
        chk("read0_addr", 32'(address_o), 32'h0000);
        wait_idle("read0_idle");
        chk("read0_rsp_cnt", rsp_cnt, 1);
        chk("read0_rsp_write", 32'(last_rsp_write), 0);
        chk("read0_rsp_data", 32'(last_rsp_data), 0);
        chk("read0_starts", issued_q.size(), 1);
        push(1'b0, 16'h0003, 4'h0);
        wait_idle("read3_idle");
        chk("read3_rsp_data", 32'(last_rsp_data), 32'h3);
        chk("read3_was_read", 32'(last_start_read), 1);

        // Fill: controller withheld, five writes back-to-back, sixth held off.
        base = rsp_cnt;
        hold = 1'b1;
        for (int i = 0; i < 5; i++) push(1'b1, 16'h0010 + 16'(i), 4'(i + 1));
        chk("fill_count", 32'(count_o), 4);
        chk("fill_ready", 32'(req_ready_o), 0);
        chk("fill_idle", 32'(idle_o), 0);
        req_valid_i   = 1'b1;
        req_write_i   = 1'b1;
        req_address_i = 16'h0015;
        req_data_i    = 4'h6;
        repeat (4) step();
        chk("fill_sixth_held", 32'(count_o), 4);
        chk("fill_no_rsp", rsp_cnt, base);
        hold = 1'b0;
        push(1'b1, 16'h0015, 4'h6);
        chk("fill_rsp_before_sixth", rsp_cnt, base + 1);
        wait_idle("fill_idle");
        chk("fill_rsp_total", rsp_cnt, base + 6);

        // Stale ready: ready_i tied high still needs the full issue/hold/wait sequence.
        tie = 1'b1;
        push(1'b1, 16'h0004, 4'h5);
        wait_idle("stale_idle");
        chk("stale_latency", last_rsp_cyc - last_start_cyc, 3);
        chk("stale_rsp_write", 32'(last_rsp_write), 1);
        chk("stale_rsp_data", 32'(last_rsp_data), 0);
        tie = 1'b0;
        push(1'b0, 16'h0004, 4'h0);
        wait_idle("stale_readback_idle");
        chk("stale_readback", 32'(last_rsp_data), 32'h5);

        // Push on the same edge as the pop; order checked on issued addresses.
        lat = 1;
        n0  = issued_q.size();
        push(1'b0, 16'h0020, 4'h0);
        push(1'b0, 16'h0021, 4'h0);
        chk("simul_count", 32'(count_o), 1);
        chk("simul_start", 32'(start_o), 1);
        push(1'b0, 16'h0022, 4'h0);
        push(1'b0, 16'h0023, 4'h0);
        wait_idle("simul_idle");
        chk("simul_n", issued_q.size() - n0, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("simul_order%0d", i), 32'(issued_q[n0 + i]), 32'h20 + i);
        chk("simul_last_data", 32'(last_rsp_data), 32'h3);

        // Reset in WAIT with two entries queued.
        lat  = 2;
        hold = 1'b1;
        push(1'b0, 16'h0030, 4'h0);
        push(1'b0, 16'h0031, 4'h0);
        push(1'b0, 16'h0032, 4'h0);
        step();
        chk("midrst_count_before", 32'(count_o), 2);
        base  = rsp_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(count_o), 0);
        chk("midrst_ready", 32'(req_ready_o), 1);
        chk("midrst_idle", 32'(idle_o), 1);
        chk("midrst_start", 32'(start_o), 0);
        chk("midrst_rsp_valid", 32'(rsp_valid_o), 0);
        chk("midrst_address", 32'(address_o), 0);
        step();
        rst_n = 1'b1;
        hold  = 1'b0;
        repeat (10) step();
        chk("midrst_no_rsp", rsp_cnt, base);
        chk("midrst_idle_after", 32'(idle_o), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmc_request_queue.md
# dmc_request_queue

CPU-side request queue sitting directly upstream of `DMC_Controller`. It accepts read and write requests from the CPU through a valid/ready handshake and buffers them in a FIFO. It issues them one at a time to the controller on the `start_from_CPU_i` / `read_i` / `write_i` / `address_from_CPU_i` / `data_from_CPU_i` inputs, waits for `ready_to_CPU_o`, and returns a one-cycle response to the CPU.

## Interface
- `BLOCK_SIZE`, 4: data word width; matches the controller.
- `ADDRESS_SIZE`, 16: address width; matches the controller.
- `QUEUE_DEPTH`, 4: FIFO entries; must be a power of two, at least 2.
- Clock and reset: one clock, `clk_i`. Reset `rst_n_i` is asynchronous and active-low.

Ports (CW = `$clog2(QUEUE_DEPTH+1)`):
- `clk_i`  in  1  clock
- `rst_n_i`  in  1  async active-low reset
- `req_valid_i`  in  1  CPU request present
- `req_ready_o`  out  1  queue can accept
- `req_write_i`  in  1  1 = write, 0 = read
- `req_address_i`  in  ADDRESS_SIZE  request address
- `req_data_i`  in  BLOCK_SIZE  write data
- `start_o`  out  1  to controller `start_from_CPU_i`
- `read_o` / `write_o`  out  1 each  to controller `read_i` / `write_i`
- `address_o`  out  ADDRESS_SIZE  to controller `address_from_CPU_i`
- `data_o`  out  BLOCK_SIZE  to controller `data_from_CPU_i`
- `ready_i`  in  1  from controller `ready_to_CPU_o`
- `data_i`  in  BLOCK_SIZE  from controller `data_to_CPU_o`
- `rsp_valid_o`  out  1  one-cycle completion pulse
- `rsp_write_o`  out  1  completed request was a write
- `rsp_data_o`  out  BLOCK_SIZE  read data; 0 for writes
- `count_o`  out  CW  queued entries, excluding the in-flight request
- `idle_o`  out  1  FSM in IDLE and `count_o` == 0

## Operation
- **Push**: on a clock edge where `req_valid_i && req_ready_o`, store {write, address, data}. `req_ready_o` = (`count_o` < `QUEUE_DEPTH`). It is combinational from the registered count and does not depend on a same-cycle pop.
- **FSM states**: IDLE, ISSUE, HOLD, WAIT.
- **IDLE**: if `count_o` > 0, pop the head into the command register and go to ISSUE.
- **ISSUE** (exactly 1 cycle): `start_o` = 1 and `read_o`/`write_o` follow the op. Go to HOLD.
- **HOLD** (exactly 1 cycle): `start_o`, `read_o` and `write_o` are 0. `ready_i` is ignored, because a stale high from the previous transaction must not complete this one. Go to WAIT.
- **WAIT**: on an edge with `ready_i` = 1, capture `data_i` (or 0 for a write) into `rsp_data_o` and set `rsp_write_o`. Pulse `rsp_valid_o` for the next cycle and go to IDLE. There is no timeout.
- **Stability**: `address_o` and `data_o` hold the command-register value from ISSUE through WAIT and keep it in IDLE until the next pop.
- **Responses**: no back-pressure; the CPU must accept `rsp_valid_o` when it is asserted.
- **Simultaneous push and pop**: `count_o` is unchanged. A push into a full queue cannot happen, because `req_ready_o` = 0.
- **Pointers**: wrap modulo `QUEUE_DEPTH`. `count_o` is the only full/empty source.

## Timing
- **Reset values**: all outputs are 0 except `req_ready_o` = 1 and `idle_o` = 1. FSM = IDLE, pointers = 0, count = 0.
- **Reset mid-operation**: the async clear abandons the in-flight controller transaction and empties the queue, and no response is produced. The controller is reset from the same `rst_n_i`.
- **Latency**:
  - A push at edge k into an empty queue with the FSM in IDLE gives `count_o` = 1 after k. The pop at k+1 drives `start_o` high during (k+1, k+2).
  - `rsp_valid_o` rises at the earliest 3 edges after `start_o` rises.
- **Throughput**: at most one request per 4 cycles plus the controller latency. IDLE lasts at least 1 cycle between requests.

## Structure
- Shared package `dmc_pkg`:
  - FSM state enum.
  - Request struct {write, address, data}.
  - Width constants reused with the controller and cache: BLOCK_OFFSET_LENGTH, INDEX_LENGTH, TAG_LENGTH.
- Sub-module `dmc_req_fifo`: storage array, read/write pointers, count, push/pop ports.
- The FSM and command register live in the top module.

## Test plan
1. **Reset**: assert `rst_n_i` = 0 for 1 cycle, then release. All outputs must read 0 except `req_ready_o` = 1 and `idle_o` = 1, with `count_o` = 0.
2. **Single read**: drive a read of address 0x0000 with the memory preloaded so each location holds its own address. Expect one `start_o` pulse with `read_o` = 1 and `address_o` = 0x0000. Then expect `rsp_valid_o` pulsed once, `rsp_write_o` = 0, `rsp_data_o` = 0.
3. **Fill**: hold `ready_i` = 0 and push 5 writes back-to-back. Expect 1 request in flight and `count_o` = 4 with `req_ready_o` = 0. The 6th request is held off until the first response.
4. **Stale ready**: tie `ready_i` = 1 and issue a write of 0x5 to address 0x0004. `rsp_valid_o` must rise exactly 3 edges after `start_o` rises, never earlier, with `rsp_write_o` = 1 and `rsp_data_o` = 0.
5. **Simultaneous push and pop**: with `count_o` = 1 and the FSM in IDLE, push on the same edge as the pop. `count_o` must stay 1, and requests must complete in FIFO order, checked by address sequence.
6. **Reset mid-operation**: assert reset while in WAIT with 2 entries queued. Outputs must return to reset values, `count_o` = 0, and no `rsp_valid_o` may appear afterwards.
